mii_frame_burst_generator: RTL and testbench
============================================

// Module: mii_frame_burst_generator
// PURPOSE
//  Parametrised XGMII-style Ethernet frame source for MII/BASE-R agent benches; successor to the single-frame generator.
//  Emits start/preamble/SFD, patterned body, terminate and programmable IFG; supports burst-count and continuous modes,
//  runtime frame length, abort/stop/error-inject interrupts. Sits upstream of the PCS encoder / checker agents.
// PARAMETERS
//  DATA_WIDTH  64    bus width, 32 or 64; LANES = DATA_WIDTH/8
//  CTRL_WIDTH  DATA_WIDTH/8  one ctrl bit per lane
//  MIN_LEN     64    minimum body length in bytes (i_frame_len clamped up)
//  MAX_LEN     1518  maximum body length in bytes (i_frame_len clamped down)
// PORTS
//  clk            in   1           single clock, all logic on rising edge
//  i_rst          in   1           synchronous, active-high reset
//  i_start        in   1           rising edge starts burst; level enables continuous mode
//  i_mode         in   1           0 = burst of i_frame_count frames, 1 = continuous while i_start high
//  i_frame_count  in   16          frames per burst (0 = burst ignored)
//  i_frame_len    in   16          body bytes after SFD, clamped to [MIN_LEN,MAX_LEN]
//  i_ifg_words    in   8           full idle words after terminate word (0 treated as 1)
//  i_seed         in   8           body byte k = (seed + k) mod 256
//  i_interrupt    in   8           01 abort, 02 stop after frame, 03 inject error; others ignored
//  o_tx_data      out  DATA_WIDTH  lane i = bits[8i+7:8i], lane 0 first on wire
//  o_tx_ctrl      out  CTRL_WIDTH  bit i = 1 -> lane i is control char
//  o_busy         out  1           high from first preamble word to end of final IFG
//  o_frames_sent  out  16          frames terminated (FD) in current burst/run
//  o_done         out  1           one-cycle pulse when burst/stop/abort returns to IDLE
// BEHAVIOUR
//  Reset: o_tx_data all lanes 0x07, o_tx_ctrl all 1, o_busy 0, o_done 0, o_frames_sent 0, state IDLE; reset mid-frame
//   gives idle word next cycle, no FD emitted.
//  All outputs registered. States: IDLE, PREAMBLE, BODY, TERM, IFG.
//  IDLE: emits idle words. Start on i_start rising edge (mode 0, i_frame_count!=0) or i_start high (mode 1);
//   clears o_frames_sent; first preamble word on the edge after i_start sampled high.
//  PREAMBLE: 8 bytes FB,55x6,D5 (ctrl only on FB lane); 1 word at 64b, 2 at 32b. Length and seed latched here per frame.
//  BODY: ceil(LEN/LANES) words, ctrl 0. If r = LEN mod LANES != 0, last body word carries r data lanes, FD at lane r,
//   07 above, ctrl set for lanes >= r; go IFG. If r == 0, go TERM: FD lane 0, 07 others, ctrl all 1.
//  o_frames_sent increments in the cycle FD is emitted (saturates at FFFF).
//  IFG: i_ifg_words idle words (latched at frame start). Then: mode 0 and frames_sent == i_frame_count -> IDLE + o_done;
//   mode 1 and i_start low -> IDLE + o_done; stop pending -> IDLE + o_done; else PREAMBLE.
//  Interrupt sampled every cycle, acts on next emitted word:
//   01 in PREAMBLE/BODY/TERM: emit all-lanes 0xFE, ctrl all 1, then IFG, then IDLE + o_done; no FD, no count. Ignored elsewhere.
//   02: set stop-pending; current frame and its IFG finish normally. Cleared on entering IDLE.
//   03: one-shot, next BODY word lane 0 forced 0xFE ctrl=1; other lanes unchanged; ignored outside a frame.
//   01 overrides a simultaneous pending 02/03. i_start edge while busy is ignored.
//  Lane counter math in 16 bits; remainder via LEN mod LANES (LANES power of two).
// TESTING
//  1. 64b, mode0, count1, len64, seed00, ifg1 -> D5555555555555FB/ctrl01, 8 body words 0706..00 ... 3F3E..38/ctrl00,
//     07070707070707FD/ctrl FF, one idle word, o_done pulse, o_frames_sent=1.
//  2. len67 -> last word lanes0-2 data 40,41,42, lane3 FD, lanes4-7 07, ctrl F8; no separate TERM word.
//  3. mode0, count3, ifg4 -> exactly 3 FB starts, 4 idle words between each FD word and next FB, o_frames_sent=3.
//  4. i_interrupt=01 at body word 3 -> next word FEFEFEFEFEFEFEFE/ctrl FF, no FD, busy low after IFG, frames_sent=0.
//  5. mode1, i_start held, i_interrupt=02 mid frame 2 -> frame 2 ends with FD, no further FB, frames_sent=2.
//  6. len10 -> clamped to 64 body bytes; DATA_WIDTH=32 len64 -> 2 preamble words, 16 body words, FD word 070707FD/ctrl F.

Source files
------------

// File: rtl/mii_frame_burst_generator.sv
// XGMII-style frame burst source: preamble/SFD, seeded body, terminate, IFG.
// Burst-count or continuous mode with abort, stop-after-frame and error inject.
module mii_frame_burst_generator #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int MIN_LEN    = 64,
   parameter int MAX_LEN    = 1518
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_mode,
   input  logic [15:0]           i_frame_count,
   input  logic [15:0]           i_frame_len,
   input  logic [7:0]            i_ifg_words,
   input  logic [7:0]            i_seed,
   input  logic [7:0]            i_interrupt,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
   output logic                  o_busy,
   output logic [15:0]           o_frames_sent,
   output logic                  o_done
);

   localparam int LANES     = DATA_WIDTH / 8;
   localparam int LB        = $clog2(LANES);
   localparam int PRE_WORDS = 8 / LANES;

   localparam logic [63:0] PRE = 64'hD5555555555555FB;
   localparam logic [DATA_WIDTH-1:0] W_IDLE  = {LANES{8'h07}};
   localparam logic [DATA_WIDTH-1:0] W_ABORT = {LANES{8'hFE}};
   localparam logic [DATA_WIDTH-1:0] W_TERM  = {{(LANES-1){8'h07}}, 8'hFD};
   localparam logic [15:0] LEN_MIN = 16'(MIN_LEN);
   localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, BODY, TERM, IFG
   } state_t;

   state_t state, state_d;

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic                  busy_q, done_q, done_d;
   logic [15:0]           sent_q, sent_d, sent_inc;
   logic                  start_q;
   logic [15:0]           len_q, len_d;
   logic [7:0]            seed_q, seed_d;
   logic [7:0]            ifg_q, ifg_d;
   logic [15:0]           wcnt, wcnt_d;
   logic [7:0]            icnt, icnt_d;
   logic                  pcnt, pcnt_d;
   logic                  stop_q, stop_d;
   logic                  err_q, err_d;
   logic                  abort_q, abort_d;

   logic [15:0] clen, rem, nwords, last_w, body_idx;
   logic [7:0]  ifg_eff;
   logic        start_ok, in_frame, abort_req, err_req, end_run;
   logic        go_pre, go_body, body_fd;

   function automatic logic [CTRL_WIDTH+DATA_WIDTH-1:0] body_word(
      input logic [15:0] w,
      input logic        fd_last,
      input logic [15:0] r,
      input logic [7:0]  seed,
      input logic        err
   );
      logic [DATA_WIDTH-1:0] d;
      logic [CTRL_WIDTH-1:0] c;
      logic [15:0]           k, lane;
      d = '0;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         lane = 16'(i);
         k    = (w << LB) + lane;
         if (fd_last && lane > r) begin
            d[8*i +: 8] = 8'h07;
            c[i]        = 1'b1;
         end else if (fd_last && lane == r) begin
            d[8*i +: 8] = 8'hFD;
            c[i]        = 1'b1;
         end else begin
            d[8*i +: 8] = seed + k[7:0];
         end
      end
      if (err) begin
         d[7:0] = 8'hFE;
         c[0]   = 1'b1;
      end
      return {c, d};
   endfunction

   assign clen = (i_frame_len < LEN_MIN) ? LEN_MIN :
                 (i_frame_len > LEN_MAX) ? LEN_MAX : i_frame_len;
   assign rem      = len_q & 16'(LANES - 1);
   assign nwords   = (len_q + 16'(LANES - 1)) >> LB;
   assign last_w   = nwords - 16'd1;
   assign ifg_eff  = (ifg_q == 8'd0) ? 8'd1 : ifg_q;
   assign sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;

   // Mode 0 starts on a rising edge only; mode 1 runs on level.
   assign start_ok = i_mode ? i_start
                            : (i_start & ~start_q & (i_frame_count != 16'd0));
   assign in_frame  = (state == PREAMBLE) || (state == BODY) ||
                      (state == TERM);
   assign abort_req = in_frame && (i_interrupt == 8'h01);
   assign err_req   = err_q || (in_frame && (i_interrupt == 8'h03));
   assign end_run   = abort_q || stop_q || (i_interrupt == 8'h02) ||
                      (i_mode ? ~i_start : (sent_q >= i_frame_count));

   always_comb begin
      state_d  = state;
      data_d   = W_IDLE;
      ctrl_d   = '1;
      done_d   = 1'b0;
      sent_d   = sent_q;
      len_d    = len_q;
      seed_d   = seed_q;
      ifg_d    = ifg_q;
      wcnt_d   = wcnt;
      icnt_d   = icnt;
      pcnt_d   = pcnt;
      stop_d   = stop_q || ((state != IDLE) && (i_interrupt == 8'h02));
      err_d    = err_req;
      abort_d  = abort_q;
      go_pre   = 1'b0;
      go_body  = 1'b0;
      body_idx = wcnt;
      body_fd  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start_ok) begin
               go_pre = 1'b1;
               sent_d = '0;
            end
         end
         PREAMBLE: begin
            if (pcnt != 1'(PRE_WORDS - 1)) begin
               data_d = PRE[63 -: DATA_WIDTH];
               ctrl_d = '0;
               pcnt_d = 1'b1;
            end else begin
               go_body  = 1'b1;
               body_idx = 16'd0;
            end
         end
         BODY: begin
            if (wcnt != last_w) begin
               go_body  = 1'b1;
               body_idx = wcnt + 16'd1;
            end else if (rem == 16'd0) begin
               state_d = TERM;
               data_d  = W_TERM;
               sent_d  = sent_inc;
            end else begin
               state_d = IFG;
               icnt_d  = 8'd1;
            end
         end
         TERM: begin
            state_d = IFG;
            icnt_d  = 8'd1;
         end
         IFG: begin
            if (icnt < ifg_eff) begin
               icnt_d = icnt + 8'd1;
            end else if (end_run) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               go_pre = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (go_pre) begin
         state_d = PREAMBLE;
         data_d  = PRE[DATA_WIDTH-1:0];
         ctrl_d  = CTRL_WIDTH'(1);
         pcnt_d  = 1'b0;
         len_d   = clen;
         seed_d  = i_seed;
         ifg_d   = i_ifg_words;
         abort_d = 1'b0;
         err_d   = 1'b0;
      end

      if (go_body) begin
         body_fd = (body_idx == last_w) && (rem != 16'd0);
         state_d = BODY;
         wcnt_d  = body_idx;
         {ctrl_d, data_d} = body_word(body_idx, body_fd, rem,
                                      seed_q, err_req);
         err_d   = 1'b0;
         if (body_fd) sent_d = sent_inc;
      end

      // Abort replaces whatever word was due, including a pending FD.
      if (abort_req) begin
         state_d = TERM;
         data_d  = W_ABORT;
         ctrl_d  = '1;
         sent_d  = sent_q;
         wcnt_d  = wcnt;
         abort_d = 1'b1;
         err_d   = 1'b0;
      end

      if ((state_d != PREAMBLE) && (state_d != BODY)) err_d = 1'b0;
      if (state_d == IDLE) begin
         stop_d  = 1'b0;
         abort_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state   <= IDLE;
         data_q  <= W_IDLE;
         ctrl_q  <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sent_q  <= '0;
         start_q <= 1'b0;
         len_q   <= LEN_MIN;
         seed_q  <= '0;
         ifg_q   <= 8'd1;
         wcnt    <= '0;
         icnt    <= '0;
         pcnt    <= 1'b0;
         stop_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         sent_q  <= sent_d;
         start_q <= i_start;
         len_q   <= len_d;
         seed_q  <= seed_d;
         ifg_q   <= ifg_d;
         wcnt    <= wcnt_d;
         icnt    <= icnt_d;
         pcnt    <= pcnt_d;
         stop_q  <= stop_d;
         err_q   <= err_d;
         abort_q <= abort_d;
      end
   end

   assign o_tx_data     = data_q;
   assign o_tx_ctrl     = ctrl_q;
   assign o_busy        = busy_q;
   assign o_frames_sent = sent_q;
   assign o_done        = done_q;

endmodule

// File: tb/tb_mii_frame_burst_generator.sv
// Bench for mii_frame_burst_generator: byte-stream reference model vs
// captured word streams of a 64-bit and a 32-bit instance.
module tb_mii_frame_burst_generator;

   typedef logic [71:0] word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start32, mode;
   logic [15:0] fcount, flen;
   logic [7:0]  ifg, seed, intr;
   logic [63:0] txd;
   logic [7:0]  txc;
   logic        busy, done;
   logic [15:0] sent;
   logic [31:0] txd32;
   logic [3:0]  txc32;
   logic        busy32, done32;
   logic [15:0] sent32;

   int n_cmp = 0;
   int n_bad = 0;
   word_t exp_q[$];
   word_t cap_q[$];

   mii_frame_burst_generator #(.DATA_WIDTH(64)) dut (
      .clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
      .i_frame_count(fcount), .i_frame_len(flen), .i_ifg_words(ifg),
      .i_seed(seed), .i_interrupt(intr), .o_tx_data(txd),
      .o_tx_ctrl(txc), .o_busy(busy), .o_frames_sent(sent),
      .o_done(done)
   );

   mii_frame_burst_generator #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .i_rst(rst), .i_start(start32), .i_mode(mode),
      .i_frame_count(fcount), .i_frame_len(flen), .i_ifg_words(ifg),
      .i_seed(seed), .i_interrupt(intr), .o_tx_data(txd32),
      .o_tx_ctrl(txc32), .o_busy(busy32), .o_frames_sent(sent32),
      .o_done(done32)
   );

   task automatic check(input string tag, input logic [71:0] got,
                        input logic [71:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic int clampl(input int l);
      return (l < 64) ? 64 : ((l > 1518) ? 1518 : l);
   endfunction

   function automatic int frame_words(input int lanes, input int l);
      return (8 + clampl(l) + 1 + lanes - 1) / lanes;
   endfunction

   function automatic word_t idle_w(input int lanes);
      word_t x = '0;
      for (int i = 0; i < lanes; i++) begin
         x[8*i +: 8] = 8'h07;
         x[64+i]     = 1'b1;
      end
      return x;
   endfunction

   // Whole frame as a byte/ctrl stream, then chopped into lane words.
   function automatic void add_frame(input int lanes, input int l,
                                     input logic [7:0] sd, input int g);
      logic [7:0] b[$];
      logic       c[$];
      int         n = clampl(l);
      b.push_back(8'hFB); c.push_back(1'b1);
      repeat (6) begin b.push_back(8'h55); c.push_back(1'b0); end
      b.push_back(8'hD5); c.push_back(1'b0);
      for (int k = 0; k < n; k++) begin
         b.push_back(8'(int'(sd) + k));
         c.push_back(1'b0);
      end
      b.push_back(8'hFD); c.push_back(1'b1);
      while ((b.size() % lanes) != 0) begin
         b.push_back(8'h07); c.push_back(1'b1);
      end
      for (int w = 0; w < b.size() / lanes; w++) begin
         word_t x = '0;
         for (int i = 0; i < lanes; i++) begin
            x[8*i +: 8] = b[w*lanes+i];
            x[64+i]     = c[w*lanes+i];
         end
         exp_q.push_back(x);
      end
      repeat ((g == 0) ? 1 : g) exp_q.push_back(idle_w(lanes));
   endfunction

   function automatic word_t cur_word(input bit wide);
      return wide ? {txc, txd} : {4'h0, txc32, 32'h0, txd32};
   endfunction

   task automatic run_burst(input bit wide, input int inj_idx,
                            input logic [7:0] code, input int drop_idx);
      int idx = 0;
      cap_q.delete();
      @(negedge clk);
      if (!mode) begin start = 1'b0; start32 = 1'b0; end
      check("busy_start", wide ? busy : busy32, 1'b1);
      while ((wide ? busy : busy32) && idx < 5000) begin
         cap_q.push_back(cur_word(wide));
         intr = 8'h00;
         if (idx == inj_idx) intr = code;
         if (idx == drop_idx) begin start = 1'b0; start32 = 1'b0; end
         idx++;
         @(negedge clk);
      end
      start = 1'b0; start32 = 1'b0; intr = 8'h00;
      check("busy_end", wide ? busy : busy32, 1'b0);
      check("done_pulse", wide ? done : done32, 1'b1);
      check("idle_after", cur_word(wide), idle_w(wide ? 8 : 4));
      @(negedge clk);
      check("done_clear", wide ? done : done32, 1'b0);
   endtask

   task automatic compare_stream(input string tag,
                                 input logic [15:0] sent_got,
                                 input int sent_exp);
      check({tag, "_len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i), cap_q[i], exp_q[i]);
      check({tag, "_sent"}, sent_got, 16'(sent_exp));
   endtask

   task automatic setup(input logic m, input int cnt, input int l,
                        input logic [7:0] sd, input int g);
      mode   = m;
      fcount = 16'(cnt);
      flen   = 16'(l);
      seed   = sd;
      ifg    = 8'(g);
      exp_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, l, g, fw, nb, k, nfr;
      logic [7:0] sd, code;
      logic seen;
      word_t x;
      word_t tmp[$];

      rst = 1'b1; start = 1'b0; start32 = 1'b0; mode = 1'b0;
      fcount = 16'd1; flen = 16'd64; ifg = 8'd1; seed = 8'd0;
      intr = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_word", {txc, txd}, idle_w(8));
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sent", sent, 16'd0);
      check("rst_word32", cur_word(1'b0), idle_w(4));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      setup(1'b0, 1, 64, 8'h00, 1);
      add_frame(8, 64, 8'h00, 1);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, -1);
      compare_stream("t1", sent, 1);
      if (cap_q.size() > 9) begin
         check("t1_pre", cap_q[0], {8'h01, 64'hD5555555555555FB});
         check("t1_b0", cap_q[1], {8'h00, 64'h0706050403020100});
         check("t1_b7", cap_q[8], {8'h00, 64'h3F3E3D3C3B3A3938});
         check("t1_fd", cap_q[9], {8'hFF, 64'h07070707070707FD});
      end
      repeat (2) @(negedge clk);

      setup(1'b0, 1, 67, 8'h00, 1);
      add_frame(8, 67, 8'h00, 1);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, -1);
      compare_stream("t2", sent, 1);
      if (cap_q.size() > 9)
         check("t2_last", cap_q[9], {8'hF8, 64'h07070707FD424140});
      repeat (2) @(negedge clk);

      sd = 8'($urandom);
      setup(1'b0, 3, 64 + $urandom_range(0, 40), sd, 4);
      repeat (3) add_frame(8, int'(flen), sd, 4);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, -1);
      compare_stream("t3", sent, 3);
      repeat (2) @(negedge clk);

      setup(1'b0, 1, 10, 8'h5A, 0);
      add_frame(8, 10, 8'h5A, 0);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, -1);
      compare_stream("clamp_lo", sent, 1);
      repeat (2) @(negedge clk);

      setup(1'b0, 1, 2000, 8'hC3, 2);
      add_frame(8, 2000, 8'hC3, 2);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, -1);
      compare_stream("clamp_hi", sent, 1);
      repeat (2) @(negedge clk);

      for (int it = 0; it < 6; it++) begin
         cnt  = $urandom_range(1, 3);
         l    = $urandom_range(0, 300);
         g    = $urandom_range(0, 5);
         sd   = 8'($urandom);
         code = 8'($urandom_range(4, 255));
         setup(1'b0, cnt, l, sd, g);
         repeat (cnt) add_frame(8, l, sd, g);
         start = 1'b1;
         run_burst(1'b1, $urandom_range(0, 20), code, -1);
         compare_stream($sformatf("rnd%0d", it), sent, cnt);
         repeat (2) @(negedge clk);
      end

      for (int it = 0; it < 3; it++) begin
         l  = $urandom_range(64, 200);
         g  = $urandom_range(1, 3);
         sd = 8'($urandom);
         nb = (l + 7) / 8;
         k  = (it == 0) ? 4 : $urandom_range(0, nb - 1);
         setup(1'b0, $urandom_range(1, 3), l, sd, g);
         add_frame(8, l, sd, g);
         tmp.delete();
         for (int i = 0; i <= k; i++) tmp.push_back(exp_q[i]);
         tmp.push_back({8'hFF, {8{8'hFE}}});
         repeat (g) tmp.push_back(idle_w(8));
         exp_q = tmp;
         start = 1'b1;
         run_burst(1'b1, k, 8'h01, -1);
         compare_stream($sformatf("abort%0d", it), sent, 0);
         repeat (2) @(negedge clk);
      end

      for (int it = 0; it < 2; it++) begin
         l  = $urandom_range(64, 120);
         g  = $urandom_range(1, 3);
         sd = 8'($urandom);
         nb = (clampl(l) + 7) / 8;
         k  = $urandom_range(0, nb - 1);
         setup(1'b0, 1, l, sd, g);
         add_frame(8, l, sd, g);
         x = exp_q[k+1];
         x[7:0] = 8'hFE;
         x[64]  = 1'b1;
         exp_q[k+1] = x;
         start = 1'b1;
         run_burst(1'b1, k, 8'h03, -1);
         compare_stream($sformatf("err%0d", it), sent, 1);
         repeat (2) @(negedge clk);
      end

      l  = $urandom_range(64, 100);
      g  = $urandom_range(1, 3);
      sd = 8'($urandom);
      fw = frame_words(8, l) + g;
      setup(1'b1, 0, l, sd, g);
      repeat (2) add_frame(8, l, sd, g);
      start = 1'b1;
      run_burst(1'b1, fw + $urandom_range(1, fw - g - 1), 8'h02, -1);
      compare_stream("stop", sent, 2);
      repeat (2) @(negedge clk);

      nfr = $urandom_range(1, 3);
      l   = $urandom_range(64, 100);
      g   = $urandom_range(0, 3);
      sd  = 8'($urandom);
      fw  = frame_words(8, l) + ((g == 0) ? 1 : g);
      setup(1'b1, 0, l, sd, g);
      repeat (nfr) add_frame(8, l, sd, g);
      start = 1'b1;
      run_burst(1'b1, -1, 8'h00, (nfr - 1) * fw + $urandom_range(0, fw - 1));
      compare_stream("cont", sent, nfr);
      repeat (2) @(negedge clk);

      setup(1'b0, 3, 64, 8'h11, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);
      check("mid_sent", sent, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_word", {txc, txd}, idle_w(8));
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_sent", sent, 16'd0);
      check("mid_rst_done", done, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_word", {txc, txd}, idle_w(8));

      setup(1'b0, 0, 64, 8'h00, 1);
      start = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) seen = 1'b1;
      end
      check("count0_busy", seen, 1'b0);

      sd = 8'($urandom);
      setup(1'b0, 1, 64, sd, 1);
      add_frame(4, 64, sd, 1);
      start32 = 1'b1;
      run_burst(1'b0, -1, 8'h00, -1);
      compare_stream("w32", sent32, 1);
      if (cap_q.size() > 18) begin
         check("w32_pre1", cap_q[1], {8'h00, 64'hD5555555});
         check("w32_fd", cap_q[18], {8'h0F, 64'h070707FD});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
